// File: rtl/aes_inv_mc_pkg.sv
// aes_inv_mc_pkg: shared types, sizes and helpers for the serialized (inverse) MixColumns unit
package aes_inv_mc_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam int NCOLS = 4;
  localparam int COL_W = 32;
  function automatic bit cpc_legal(input int n);
    return n == 1 || n == 2 || n == 4;
  endfunction
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
endpackage

// File: rtl/aes_inv_mc_single_column.sv
// aes_inv_mc_single_column: one-column inverse MixColumns; forward mode selectable under AES_MC_DUAL_MODE_EN
module aes_inv_mc_single_column
  import aes_inv_mc_pkg::*;
(
`ifdef AES_MC_DUAL_MODE_EN
  input  logic        inverse,
`endif
  input  logic [31:0] col,
  output logic [31:0] mixed
);
  logic [7:0] a [4];
  logic [7:0] x2 [4];
  logic [7:0] x4 [4];
  logic [7:0] x8 [4];
  for (genvar i = 0; i < 4; i++) begin : g_row
    localparam int J1 = (i + 1) % 4;
    localparam int J2 = (i + 2) % 4;
    localparam int J3 = (i + 3) % 4;
    logic [7:0] inv;
    assign a[i]  = col[8*i +: 8];
    assign x2[i] = xtime(a[i]);
    assign x4[i] = xtime(x2[i]);
    assign x8[i] = xtime(x4[i]);
    // 14*a_i ^ 11*a_i+1 ^ 13*a_i+2 ^ 9*a_i+3
    assign inv = (x8[i] ^ x4[i] ^ x2[i]) ^ (x8[J1] ^ x2[J1] ^ a[J1])
               ^ (x8[J2] ^ x4[J2] ^ a[J2]) ^ (x8[J3] ^ a[J3]);
`ifdef AES_MC_DUAL_MODE_EN
    assign mixed[8*i +: 8] = inverse ? inv : (x2[i] ^ x2[J1] ^ a[J1] ^ a[J2] ^ a[J3]);
`else
    assign mixed[8*i +: 8] = inv;
`endif
  end
endmodule

// File: rtl/aes_inv_mc_serial.sv
// aes_inv_mc_serial: serialized in-place inverse MixColumns over valid/ready; AES_MC_DUAL_MODE_EN adds in_inverse
module aes_inv_mc_serial
  import aes_inv_mc_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
`ifdef AES_MC_DUAL_MODE_EN
  input  logic         in_inverse,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);
  if (!cpc_legal(COLS_PER_CYCLE)) begin : g_bad_cpc
    $error("aes_inv_mc_serial: COLS_PER_CYCLE must be 1, 2 or 4");
  end
  state_t       state;
  logic [1:0]   col_cnt;
  logic [127:0] buffer;
  logic [127:0] buf_nxt;
  logic [1:0]   idx [COLS_PER_CYCLE];
  logic [31:0]  col_in [COLS_PER_CYCLE];
  logic [31:0]  col_out [COLS_PER_CYCLE];
  logic         accept;
  logic         last;
`ifdef AES_MC_DUAL_MODE_EN
  logic         inv_q;
`endif
  for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
    assign idx[k]    = col_cnt + 2'(k);
    assign col_in[k] = buffer[COL_W*idx[k] +: COL_W];
    aes_inv_mc_single_column u_col (
`ifdef AES_MC_DUAL_MODE_EN
      .inverse (inv_q),
`endif
      .col     (col_in[k]),
      .mixed   (col_out[k])
    );
  end
  always_comb begin
    buf_nxt = buffer;
    for (int k = 0; k < COLS_PER_CYCLE; k++) buf_nxt[COL_W*idx[k] +: COL_W] = col_out[k];
  end
  assign last      = (3'(col_cnt) + 3'(COLS_PER_CYCLE)) == 3'(NCOLS);
  assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = state == DONE;
  assign out_data  = buffer;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      col_cnt <= '0;
      buffer  <= '0;
`ifdef AES_MC_DUAL_MODE_EN
      inv_q   <= 1'b0;
`endif
    end else if (accept) begin
      state   <= BUSY;
      col_cnt <= '0;
      buffer  <= in_data;
`ifdef AES_MC_DUAL_MODE_EN
      inv_q   <= in_inverse;
`endif
    end else if (state == BUSY) begin
      state   <= last ? DONE : BUSY;
      col_cnt <= col_cnt + 2'(COLS_PER_CYCLE);
      buffer  <= buf_nxt;
    end else if (state == DONE && out_ready) begin
      state   <= IDLE;
    end
  end
endmodule

// File: tb/tb_aes_inv_mc_serial.sv
// tb_aes_inv_mc_serial: scoreboard bench for aes_inv_mc_serial (COLS_PER_CYCLE 1/2/4; dual-mode tests when AES_MC_DUAL_MODE_EN)
module tb_aes_inv_mc_serial;
  localparam logic [127:0] VEC = 128'hd6d7d5d5_01010101_9d58dc9f_bca14d8e;
  localparam logic [127:0] EXP = 128'hd5d4d4d4_01010101_5c220af2_455313db;
  logic         clk = 0;
  logic         rst_n = 0;
  logic         in_valid = 0, in_valid_b = 0, out_ready = 1, one = 1;
  logic         in_inverse = 1;
  logic [127:0] in_data = '0;
  logic         in_ready, out_valid, in_ready2, out_valid2, in_ready4, out_valid4;
  logic [127:0] out_data, out_data2, out_data4;
  int           n_checks = 0, n_fail = 0;
  logic [127:0] sb [$];
  always #5 clk = ~clk;
  aes_inv_mc_serial #(.COLS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
`ifdef AES_MC_DUAL_MODE_EN
    .in_inverse(in_inverse),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data));
  aes_inv_mc_serial #(.COLS_PER_CYCLE(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready2), .in_data(in_data),
`ifdef AES_MC_DUAL_MODE_EN
    .in_inverse(in_inverse),
`endif
    .out_valid(out_valid2), .out_ready(one), .out_data(out_data2));
  aes_inv_mc_serial #(.COLS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready4), .in_data(in_data),
`ifdef AES_MC_DUAL_MODE_EN
    .in_inverse(in_inverse),
`endif
    .out_valid(out_valid4), .out_ready(one), .out_data(out_data4));
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
    end
    return p;
  endfunction
  function automatic logic [127:0] mix(input logic [127:0] d, input logic inv);
    logic [7:0] k [4];
    logic [127:0] r = '0;
    k = inv ? '{8'h0e, 8'h0b, 8'h0d, 8'h09} : '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++)
      for (int o = 0; o < 4; o++)
        for (int j = 0; j < 4; j++)
          r[32*c+8*o +: 8] ^= gmul(k[j], d[32*c+8*((o+j)%4) +: 8]);
    return r;
  endfunction
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  always @(negedge clk) if (rst_n) begin
    if (in_valid && in_ready) sb.push_back(mix(in_data, in_inverse));
    if (out_valid && out_ready) begin
      if (sb.size() == 0) check("sb_unexpected_output", out_data, '0);
      else check("sb_data", out_data, sb.pop_front());
    end
  end
  // call at posedge+1; returns at accepting edge+1
  task automatic send(input logic [127:0] d);
    bit ok = 0;
    in_data = d;
    in_valid = 1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
    end
    if (!ok) check("send_timeout", 0, 1);
    @(posedge clk);
    #1 in_valid = 0;
  endtask
  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1 lat++;
    end while (!out_valid && lat < 100);
  endtask
  initial begin
    int lat, lat2, lat4;
    logic [127:0] a_res;
    #23;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, '0);
    rst_n = 1;
    @(posedge clk);
    #1 send(VEC);
    wait_out(lat);
    check("lat_cpc1", lat, 4);
    check("vec_cpc1", out_data, EXP);
    in_valid_b = 1;
    @(posedge clk);
    #1 in_valid_b = 0;
    lat2 = 0;
    lat4 = 0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      #1;
      if (out_valid2 && lat2 == 0) begin lat2 = c; check("vec_cpc2", out_data2, EXP); end
      if (out_valid4 && lat4 == 0) begin lat4 = c; check("vec_cpc4", out_data4, EXP); end
    end
    check("lat_cpc2", lat2, 2);
    check("lat_cpc4", lat4, 1);
    out_ready = 0;
    send(128'h0123456789abcdef_fedcba9876543210);
    wait_out(lat);
    check("lat_bp", lat, 4);
    a_res = mix(128'h0123456789abcdef_fedcba9876543210, 1);
    in_data = 128'h00112233_44556677_8899aabb_ccddeeff;
    in_valid = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_data_stable", out_data, a_res);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
    end
    @(posedge clk);
    #1 out_ready = 1;
    @(negedge clk);
    check("b2b_in_ready", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 0;
    wait_out(lat);
    check("lat_b2b", lat, 4);
    @(posedge clk);
    #1 send(128'hdeadbeef_cafef00d_12345678_9abcdef0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_out_data", out_data, '0);
    sb.delete();
    @(negedge clk);
    #1 rst_n = 1;
    @(posedge clk);
    #1 send(VEC);
    wait_out(lat);
    check("lat_after_rst", lat, 4);
    check("vec_after_rst", out_data, EXP);
    send({16{8'h01}});
    wait_out(lat);
    check("ident_01", out_data, {16{8'h01}});
    send({16{8'hc6}});
    wait_out(lat);
    check("ident_c6", out_data, {16{8'hc6}});
`ifdef AES_MC_DUAL_MODE_EN
    in_inverse = 0;
    send({4{32'h455313db}});
    wait_out(lat);
    check("dual_fwd", out_data, {4{32'hbca14d8e}});
    in_inverse = 1;
    send({4{32'hbca14d8e}});
    wait_out(lat);
    check("dual_inv", out_data, {4{32'h455313db}});
    send(VEC);
    @(posedge clk);
    #1 in_inverse = 0;
    wait_out(lat);
    in_inverse = 1;
    check("dual_toggle", out_data, EXP);
`endif
    @(posedge clk);
    @(posedge clk);
    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
